// File: rtl/song_reader_pkg.sv
// Shared types and constants for the song_reader sequencer: state encoding,
// default widths and the layout of a ROM word.
package song_reader_pkg;

  localparam int DEF_NOTE_ADDR_W = 5;
  localparam int DEF_NOTE_W      = 6;
  localparam int DEF_DUR_W       = 6;
  localparam int SONG_W          = 2;

  localparam int ROM_ADDR_W = SONG_W + DEF_NOTE_ADDR_W;
  localparam int ROM_DATA_W = DEF_NOTE_W + DEF_DUR_W;
  localparam int ROM_DEPTH  = 2 ** ROM_ADDR_W;

  // ROM word is {note, duration}
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DEF_DUR_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    EMIT      = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/song_reader_if.sv
// Handshake bundle between the control FSM / note player and song_reader.
// slave is the reader side; master is the driving environment.
interface song_reader_if
  import song_reader_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W
);
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic              note_done;
  logic              new_note;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              song_done;

  modport master (
    output play, reset_player, song, note_done,
    input  new_note, note, duration, song_done
  );

  modport slave (
    input  play, reset_player, song, note_done,
    output new_note, note, duration, song_done
  );
endinterface

// File: rtl/dffr.sv
// Team flop: W-bit register with asynchronous active-low reset to RST_VAL.
module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end
endmodule

// File: rtl/song_rom.sv
// 128x12 synchronous-read note ROM, four songs of 32 {note, duration} entries.
// Song 2 entry 3 carries duration 0 (end-of-song marker when enabled).
module song_rom
  import song_reader_pkg::*;
(
  input  logic                  clk,
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [ROM_DATA_W-1:0] data
);
  localparam logic [ROM_DATA_W-1:0] IMAGE [ROM_DEPTH] = '{
    // song 0
    12'h50C, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106, 12'h107, 12'h108,
    12'h109, 12'h10A, 12'h10B, 12'h10C, 12'h10D, 12'h10E, 12'h10F, 12'h110,
    12'h111, 12'h112, 12'h113, 12'h114, 12'h115, 12'h116, 12'h117, 12'h118,
    12'h119, 12'h11A, 12'h11B, 12'h11C, 12'h11D, 12'h11E, 12'h11F, 12'h120,
    // song 1
    12'h201, 12'h202, 12'h203, 12'h204, 12'h205, 12'h206, 12'h207, 12'h208,
    12'h209, 12'h20A, 12'h20B, 12'h20C, 12'h20D, 12'h20E, 12'h20F, 12'h210,
    12'h211, 12'h212, 12'h213, 12'h214, 12'h215, 12'h216, 12'h217, 12'h218,
    12'h219, 12'h21A, 12'h21B, 12'h21C, 12'h21D, 12'h21E, 12'h21F, 12'h220,
    // song 2
    12'h301, 12'h302, 12'h303, 12'h300, 12'h305, 12'h306, 12'h307, 12'h308,
    12'h309, 12'h30A, 12'h30B, 12'h30C, 12'h30D, 12'h30E, 12'h30F, 12'h310,
    12'h311, 12'h312, 12'h313, 12'h314, 12'h315, 12'h316, 12'h317, 12'h318,
    12'h319, 12'h31A, 12'h31B, 12'h31C, 12'h31D, 12'h31E, 12'h31F, 12'h320,
    // song 3
    12'h401, 12'h402, 12'h403, 12'h404, 12'h405, 12'h406, 12'h407, 12'h408,
    12'h409, 12'h40A, 12'h40B, 12'h40C, 12'h40D, 12'h40E, 12'h40F, 12'h410,
    12'h411, 12'h412, 12'h413, 12'h414, 12'h415, 12'h416, 12'h417, 12'h418,
    12'h419, 12'h41A, 12'h41B, 12'h41C, 12'h41D, 12'h41E, 12'h41F, 12'h420
  };

  // NOTE: memory read data is not reset; it is only consumed after a fetch.
  always_ff @(posedge clk) begin
    data <= IMAGE[addr];
  end
endmodule

// File: rtl/song_reader.sv
// Walks the selected song's note ROM and hands {note, duration} downstream.
// Optional SONG_READER_EOS_EN: a duration-0 entry ends the song early.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int NOTE_ADDR_W = DEF_NOTE_ADDR_W,
  parameter int NOTE_W      = DEF_NOTE_W,
  parameter int DUR_W       = DEF_DUR_W
) (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.slave  bus
);
  state_e                 state_q, state_d;
  logic [2:0]             state_raw;
  logic [NOTE_ADDR_W-1:0] idx_q, idx_d;
  logic [SONG_W-1:0]      cur_song_q, cur_song_d;
  logic [NOTE_W-1:0]      note_q, note_d;
  logic [DUR_W-1:0]       dur_q, dur_d;
  logic                   new_note_q, new_note_d;
  logic                   song_done_q, song_done_d;

  logic [ROM_ADDR_W-1:0]  rom_addr;
  logic [ROM_DATA_W-1:0]  rom_data;
  logic [NOTE_W-1:0]      rom_note;
  logic [DUR_W-1:0]       rom_dur;

  dffr #(.W(3), .RST_VAL(3'(IDLE))) u_state (
    .clk(clk), .rst_n(reset), .d(state_d), .q(state_raw)
  );
  assign state_q = state_e'(state_raw);

  dffr #(.W(NOTE_ADDR_W)) u_idx (
    .clk(clk), .rst_n(reset), .d(idx_d), .q(idx_q)
  );

  // The read is issued from IDLE with the live song so data is ready in FETCH.
  assign rom_addr = {(state_q == IDLE) ? bus.song : cur_song_q, idx_q};

  song_rom u_rom (
    .clk(clk), .addr(rom_addr), .data(rom_data)
  );

  assign rom_note = rom_data[NOTE_LSB +: NOTE_W];
  assign rom_dur  = rom_data[DUR_LSB  +: DUR_W];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_song_d  = cur_song_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    if (bus.reset_player) begin
      state_d = IDLE;
      idx_d   = '0;
      note_d  = '0;
      dur_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.play) begin
            state_d    = FETCH;
            cur_song_d = bus.song;
          end
        end
        FETCH: begin
          // Outputs load on entry to EMIT so new_note rises in the EMIT cycle.
          state_d = EMIT;
`ifdef SONG_READER_EOS_EN
          if (rom_dur != '0) begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
          end
`else
          note_d     = rom_note;
          dur_d      = rom_dur;
          new_note_d = 1'b1;
`endif
        end
        EMIT: begin
`ifdef SONG_READER_EOS_EN
          if (rom_dur == '0) begin
            state_d     = DONE;
            song_done_d = 1'b1;
          end else begin
            state_d = WAIT_DONE;
          end
`else
          state_d = WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
          if (bus.note_done) begin
            if (&idx_q) begin
              state_d     = DONE;
              song_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = IDLE;
            end
          end
        end
        DONE: begin
          idx_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_song_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      cur_song_q  <= cur_song_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign bus.new_note  = new_note_q;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.song_done = song_done_q;
endmodule
